// File: rtl/cfg_stream_loader.sv
// Streams configuration words LSB-first into the serial CRAM chain and
// assembles the bits returning from the chain into readback words.
//
// state | meaning
// IDLE  | no load since reset or abort; waiting for start
// FETCH | load active, waiting for the next word on the stream
// SHIFT | one chain bit per cycle from sreg_q
// DONE  | all CHAIN_LEN bits shifted; waiting for start
module cfg_stream_loader #(
  parameter int WORD_WIDTH = 8,
  parameter int CHAIN_LEN  = 1024,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  cfg_en,
  output logic                  cfg_bit,
  input  logic                  cfg_ret,
  output logic [WORD_WIDTH-1:0] rb_word,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  fabric_hold
);

  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] sreg_q, sreg_d;
  logic [WORD_WIDTH-1:0] rb_shift_q, rb_shift_d;
  logic [WORD_WIDTH-1:0] rb_word_q, rb_word_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]      bits_sent_q, bits_sent_d;
  logic                  rb_valid_q, rb_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;

  logic                  word_end;
  logic                  chain_end;
  logic [WORD_WIDTH-1:0] rb_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      rb_shift_q  <= '0;
      rb_word_q   <= '0;
      bit_idx_q   <= '0;
      bits_sent_q <= '0;
      rb_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      rb_shift_q  <= rb_shift_d;
      rb_word_q   <= rb_word_d;
      bit_idx_q   <= bit_idx_d;
      bits_sent_q <= bits_sent_d;
      rb_valid_q  <= rb_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    rb_shift_d  = rb_shift_q;
    rb_word_d   = rb_word_q;
    bit_idx_d   = bit_idx_q;
    bits_sent_d = bits_sent_q;
    rb_valid_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    aborted_d   = aborted_q;
    s_ready     = 1'b0;

    // Chain enable is decoded from state only so abort never glitches it.
    cfg_en    = (state_q == SHIFT);
    cfg_bit   = (state_q == SHIFT) ? sreg_q[bit_idx_q] : 1'b0;
    word_end  = (bit_idx_q == LAST_IDX);
    chain_end = (bits_sent_q == LAST_BIT);
    rb_cur            = rb_shift_q;
    rb_cur[bit_idx_q] = cfg_ret;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = FETCH;
          done_d      = 1'b0;
          aborted_d   = 1'b0;
          bits_sent_d = '0;
          bit_idx_d   = '0;
          rb_shift_d  = '0;
          busy_d      = 1'b1;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          done_d    = 1'b0;
        end else begin
          s_ready = 1'b1;
          if (s_valid) begin
            sreg_d    = s_data;
            bit_idx_d = '0;
            state_d   = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          done_d    = 1'b0;
        end else begin
          bits_sent_d = bits_sent_q + CNT_W'(1);
          bit_idx_d   = bit_idx_q + IDX_W'(1);
          if (chain_end) begin
            // Bits above bit_idx_q are still zero from the last clear.
            state_d    = DONE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            rb_word_d  = rb_cur;
            rb_valid_d = 1'b1;
            rb_shift_d = '0;
          end else if (word_end) begin
            rb_word_d  = rb_cur;
            rb_valid_d = 1'b1;
            rb_shift_d = '0;
            bit_idx_d  = '0;
            s_ready    = 1'b1;
            if (s_valid) begin
              sreg_d = s_data;
            end else begin
              state_d = FETCH;
            end
          end else begin
            rb_shift_d = rb_cur;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rb_word     = rb_word_q;
  assign rb_valid    = rb_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign fabric_hold = busy_q;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench: two loaders (16-bit and 20-bit chains) with behavioural
// CRAM chain models feeding cfg_ret.
module tb_cfg_stream_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       sel = 1'b0;
  logic       t_start = 1'b0;
  logic       t_abort = 1'b0;
  logic       t_s_valid = 1'b0;
  logic [7:0] t_s_data = 8'h00;

  logic       a_start, a_abort, a_s_valid, a_s_ready, a_cfg_en, a_cfg_bit, a_cfg_ret;
  logic       a_rb_valid, a_busy, a_done, a_aborted, a_hold;
  logic [7:0] a_rb_word;
  logic       b_start, b_abort, b_s_valid, b_s_ready, b_cfg_en, b_cfg_bit, b_cfg_ret;
  logic       b_rb_valid, b_busy, b_done, b_aborted, b_hold;
  logic [7:0] b_rb_word;

  assign a_start   = t_start & ~sel;
  assign a_abort   = t_abort & ~sel;
  assign a_s_valid = t_s_valid & ~sel;
  assign b_start   = t_start & sel;
  assign b_abort   = t_abort & sel;
  assign b_s_valid = t_s_valid & sel;

  cfg_stream_loader #(.WORD_WIDTH(8), .CHAIN_LEN(16)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .s_data(t_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .cfg_en(a_cfg_en), .cfg_bit(a_cfg_bit), .cfg_ret(a_cfg_ret),
    .rb_word(a_rb_word), .rb_valid(a_rb_valid), .busy(a_busy),
    .done(a_done), .aborted(a_aborted), .fabric_hold(a_hold)
  );

  cfg_stream_loader #(.WORD_WIDTH(8), .CHAIN_LEN(20)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .s_data(t_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .cfg_en(b_cfg_en), .cfg_bit(b_cfg_bit), .cfg_ret(b_cfg_ret),
    .rb_word(b_rb_word), .rb_valid(b_rb_valid), .busy(b_busy),
    .done(b_done), .aborted(b_aborted), .fabric_hold(b_hold)
  );

  // Chain models: first bit shifted in is the first bit out after a full load.
  // chain_a holds 0x12 then 0x34 as if previously loaded; chain_b holds all ones.
  logic [15:0] chain_a = 16'h482C;
  logic [19:0] chain_b = 20'hFFFFF;
  assign a_cfg_ret = chain_a[15];
  assign b_cfg_ret = chain_b[19];
  always @(posedge clk) if (a_cfg_en) chain_a <= {chain_a[14:0], a_cfg_bit};
  always @(posedge clk) if (b_cfg_en) chain_b <= {chain_b[18:0], b_cfg_bit};

  logic       o_s_ready, o_cfg_en, o_cfg_bit, o_rb_valid, o_busy, o_done, o_aborted, o_hold;
  logic [7:0] o_rb_word;
  assign o_s_ready  = sel ? b_s_ready  : a_s_ready;
  assign o_cfg_en   = sel ? b_cfg_en   : a_cfg_en;
  assign o_cfg_bit  = sel ? b_cfg_bit  : a_cfg_bit;
  assign o_rb_valid = sel ? b_rb_valid : a_rb_valid;
  assign o_rb_word  = sel ? b_rb_word  : a_rb_word;
  assign o_busy     = sel ? b_busy     : a_busy;
  assign o_done     = sel ? b_done     : a_done;
  assign o_aborted  = sel ? b_aborted  : a_aborted;
  assign o_hold     = sel ? b_hold     : a_hold;

  int          en_cnt, en_first, en_last, done_cyc;
  logic [31:0] en_bits;
  logic        hold_at_done, busy_at_done, ready_at_last, timed_out;
  logic [7:0]  rb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete load; word i+1 is offered gap cycles after word i's last bit.
  task automatic run_load(input logic s, input logic [23:0] words, input int nwords,
                          input int gap, input int start_at);
    int idx;
    int t_acc;
    idx = 0;
    t_acc = 0;
    sel = s;
    en_cnt = 0; en_first = -1; en_last = -1; done_cyc = -1;
    en_bits = '0; rb_q.delete(); timed_out = 1'b1; ready_at_last = 1'b0;
    hold_at_done = 1'b1; busy_at_done = 1'b1;
    t_start = 1'b1;
    step();
    t_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      t_s_valid = (idx < nwords) && (idx == 0 || c >= t_acc + 8 + gap);
      t_s_data  = (idx < 3) ? words[8*idx +: 8] : 8'h00;
      t_start   = (start_at >= 0) && (en_cnt == start_at);
      #1;
      if (o_rb_valid) rb_q.push_back(o_rb_word);
      if (o_done) begin
        done_cyc = c; hold_at_done = o_hold; busy_at_done = o_busy; timed_out = 1'b0;
        break;
      end
      if (o_cfg_en) begin
        if (en_cnt < 32) en_bits[en_cnt] = o_cfg_bit;
        if (en_first < 0) en_first = c;
        en_last = c;
        en_cnt++;
        ready_at_last = o_s_ready;
      end
      if (t_s_valid && o_s_ready) begin
        t_acc = c;
        idx++;
      end
      step();
    end
    t_s_valid = 1'b0;
    t_start = 1'b0;
  endtask

  function automatic logic [31:0] rb_at(input int i);
    return (rb_q.size() > i) ? {24'h0, rb_q[i]} : 32'hDEAD;
  endfunction

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    t_s_valid = 1'b1;
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_aborted", a_aborted, 0);
    chk("rst_cfg_en", a_cfg_en, 0);
    chk("rst_rb_valid", a_rb_valid, 0);
    chk("rst_rb_word", a_rb_word, 0);
    chk("rst_hold", a_hold, 0);
    chk("idle_s_ready", a_s_ready, 0);
    step();
    chk("idle_valid_no_shift", a_cfg_en, 0);
    t_s_valid = 1'b0;

    // Back-to-back 0xA5, 0x3C; chain returns preloaded 0x12, 0x34
    run_load(1'b0, {8'h00, 8'h3C, 8'hA5}, 2, 0, -1);
    chk("l1_timeout", timed_out, 0);
    chk("l1_en_cnt", en_cnt, 16);
    chk("l1_en_span", en_last - en_first + 1, 16);
    chk("l1_bits", en_bits, 32'h3CA5);
    chk("l1_done_next", done_cyc, en_last + 1);
    chk("l1_hold_at_done", hold_at_done, 0);
    chk("l1_busy_at_done", busy_at_done, 0);
    chk("l1_ready_final", ready_at_last, 0);
    chk("l1_rb_cnt", rb_q.size(), 2);
    chk("l1_rb0", rb_at(0), 32'h12);
    chk("l1_rb1", rb_at(1), 32'h34);

    run_load(1'b0, {8'h00, 8'h00, 8'hFF}, 2, 0, -1);
    chk("l2_en_cnt", en_cnt, 16);
    chk("l2_rb0", rb_at(0), 32'hA5);
    chk("l2_rb1", rb_at(1), 32'h3C);

    // Five-cycle stall between words
    run_load(1'b0, {8'h00, 8'h3C, 8'hA5}, 2, 5, -1);
    chk("l3_timeout", timed_out, 0);
    chk("l3_en_cnt", en_cnt, 16);
    chk("l3_gap_low", (en_last - en_first + 1) - en_cnt, 5);
    chk("l3_bits", en_bits, 32'h3CA5);
    chk("l3_rb0", rb_at(0), 32'hFF);
    chk("l3_rb1", rb_at(1), 32'h00);

    t_s_valid = 1'b1;
    #1;
    chk("done_s_ready", a_s_ready, 0);
    step();
    chk("done_valid_no_shift", a_cfg_en, 0);
    chk("done_sticky", a_done, 1);
    t_s_valid = 1'b0;

    // Abort after 11 bits
    t_start = 1'b1;
    step();
    t_start = 1'b0;
    chk("start_busy", a_busy, 1);
    chk("start_hold", a_hold, 1);
    chk("start_clr_done", a_done, 0);
    t_s_valid = 1'b1; t_s_data = 8'hA5;
    step();
    t_s_data = 8'h3C;
    repeat (11) step();
    t_abort = 1'b1;
    step();
    t_abort = 1'b0; t_s_valid = 1'b0;
    #1;
    chk("ab_cfg_en", a_cfg_en, 0);
    chk("ab_busy", a_busy, 0);
    chk("ab_aborted", a_aborted, 1);
    chk("ab_done", a_done, 0);
    chk("ab_hold", a_hold, 0);
    chk("ab_rb_valid", a_rb_valid, 0);

    // Abort wins over a handshake in FETCH
    t_start = 1'b1;
    step();
    t_start = 1'b0;
    chk("start_clr_aborted", a_aborted, 0);
    t_s_valid = 1'b1; t_s_data = 8'hA5; t_abort = 1'b1;
    step();
    t_abort = 1'b0; t_s_valid = 1'b0;
    #1;
    chk("abh_cfg_en", a_cfg_en, 0);
    chk("abh_aborted", a_aborted, 1);
    chk("abh_busy", a_busy, 0);
    step();
    chk("abh_no_shift", a_cfg_en, 0);

    // Full load after abort, with a start pulse mid-shift
    run_load(1'b0, {8'h00, 8'h3C, 8'hA5}, 2, 0, 3);
    chk("l4_timeout", timed_out, 0);
    chk("l4_en_cnt", en_cnt, 16);
    chk("l4_en_span", en_last - en_first + 1, 16);
    chk("l4_bits", en_bits, 32'h3CA5);
    chk("l4_aborted", a_aborted, 0);
    chk("l4_done", a_done, 1);

    // 20-bit chain: partial last word
    run_load(1'b1, {8'h0F, 8'h02, 8'h01}, 3, 0, -1);
    chk("b_timeout", timed_out, 0);
    chk("b_en_cnt", en_cnt, 20);
    chk("b_en_span", en_last - en_first + 1, 20);
    chk("b_bits", en_bits, 32'hF0201);
    chk("b_last4", en_bits[19:16], 4'hF);
    chk("b_rb_cnt", rb_q.size(), 3);
    chk("b_rb0", rb_at(0), 32'hFF);
    chk("b_rb1", rb_at(1), 32'hFF);
    chk("b_rb2_pad", rb_at(2), 32'h0F);

    // Reset in SHIFT with a coincident start
    sel = 1'b1;
    t_start = 1'b1;
    step();
    t_start = 1'b0;
    t_s_valid = 1'b1; t_s_data = 8'h5A;
    step();
    t_s_valid = 1'b0;
    repeat (4) step();
    chk("pre_rst_cfg_en", b_cfg_en, 1);
    rst = 1'b1; t_start = 1'b1;
    step();
    rst = 1'b0; t_start = 1'b0;
    #1;
    chk("mrst_cfg_en", b_cfg_en, 0);
    chk("mrst_cfg_bit", b_cfg_bit, 0);
    chk("mrst_busy", b_busy, 0);
    chk("mrst_done", b_done, 0);
    chk("mrst_aborted", b_aborted, 0);
    chk("mrst_hold", b_hold, 0);
    chk("mrst_rb_valid", b_rb_valid, 0);
    chk("mrst_rb_word", b_rb_word, 0);
    chk("mrst_s_ready", b_s_ready, 0);
    step();
    chk("mrst_start_ignored", b_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
